boot_loader_ctrl: RTL
=====================

# boot_loader_ctrl

Boot-time loader that receives a program image as a byte stream from the UART receiver and writes it word by word into instruction SRAM through the boot port of the SRAM multiplexer. It drives `boot_mode`, `boot_mem_wr_en`, `boot_mem_addr` and `boot_mem_rd_data` on that multiplexer. It releases the SRAM to the DLX once the image is complete or the transfer fails.

## Interface
Parameters:
- `DATA_WIDTH`, 32: SRAM word width; fixed at 32 (4 bytes per word).
- `ADDR_WIDTH`, 20: SRAM word-address width.
- `TIMEOUT_CYCLES`, 1_000_000: maximum idle cycles between bytes during a transfer.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `boot_start` in 1: one-cycle request to begin loading; honoured only in IDLE, DONE or ERROR.
- `rx_data` in 8: received byte.
- `rx_valid` in 1: `rx_data` is valid this cycle. May be high every cycle. There is no backpressure.
- `boot_mode` out 1: loader owns the SRAM.
- `boot_mem_wr_en` out 1: one-cycle SRAM write strobe.
- `boot_mem_addr` out ADDR_WIDTH: write word address.
- `boot_mem_rd_data` out DATA_WIDTH: write data.
- `boot_done` out 1: one-cycle pulse when the image has been fully written.
- `boot_error` out 1: sticky failure flag; cleared by `boot_start` or reset.

## Operation
Image format, all fields big-endian (first byte received = bits [31:24]):
- 4-byte word count N.
- N data words of 4 bytes each, written to addresses 0 through N-1.

States:
- IDLE: `boot_mode`=0. `boot_start` sets `boot_mode`=1, clears `boot_error`, byte index and address, and goes to LEN.
- LEN: assemble 4 bytes into N.
  - N==0 or N > 2^ADDR_WIDTH: go to ERROR.
  - Otherwise: store N and go to DATA.
- DATA: assemble 4-byte words.
  - On the 4th byte, register the word and address for a write.
  - The address increments after each write.
  - After the write of word N-1, go to DONE.
- DONE: `boot_mode`=0, `boot_done` pulsed once. `boot_start` restarts the load.
- ERROR: `boot_mode`=0, `boot_error`=1. `boot_start` restarts the load.

Rules:
- `rx_valid` is ignored in IDLE, DONE and ERROR.
- `boot_start` is ignored in LEN and DATA.
- The timeout counter runs in LEN and DATA and reloads on every accepted byte and on entry to LEN. On expiry it goes to ERROR and discards any partially assembled word; words already written remain in SRAM.
- Reset values: `boot_mode`=0, `boot_mem_wr_en`=0, `boot_mem_addr`=0, `boot_mem_rd_data`=0, `boot_done`=0, `boot_error`=0, state IDLE.
- Reset mid-transfer aborts immediately with no further writes.

## Timing
- All outputs are registered.
- `boot_start` at cycle t gives `boot_mode`=1 at t+1.
- 4th byte of a word accepted at cycle t:
  - At t+1, `boot_mem_wr_en`=1 for exactly one cycle, with `boot_mem_addr` and `boot_mem_rd_data` valid.
  - Address and data hold their values until the next write.
- Byte assembly continues during the write cycle, so back-to-back bytes (one per cycle) sustain one write every 4 cycles without loss.
- Last word (4th byte of word N-1 accepted at t):
  - Write strobe at t+1.
  - At t+2, `boot_mode`=0 and `boot_done`=1 for one cycle.
  - The SRAM is therefore never switched to the DLX during a boot write.
- Length error (4th length byte at t): `boot_mode`=0 and `boot_error`=1 at t+1.
- Timeout:
  - The counter counts cycles since the last accepted byte.
  - At count TIMEOUT_CYCLES, the next cycle shows `boot_mode`=0 and `boot_error`=1.
  - A byte arriving in the expiry cycle is discarded.
- Address arithmetic: a word count of exactly 2^ADDR_WIDTH is legal. The final address is 2^ADDR_WIDTH-1; the internal counter does not wrap before DONE.

## Structure
- A shared include, `boot_defs.vh`, holds:
  - the state encoding localparams (IDLE, LEN, DATA, DONE, ERROR);
  - the bytes-per-word constant (4).
- Sub-module `byte_packer`:
  - shifts `rx_data` into a 32-bit register;
  - a 2-bit byte index selects the byte lane;
  - outputs `word` and a one-cycle `word_valid`;
  - has a `clear` input.
- The top level holds the FSM, word counter, address register, timeout counter and output registers.

## Test plan
- Image with N=2, bytes 00 00 00 02 DE AD BE EF 01 23 45 67, one byte per cycle:
  - two single-cycle writes: addr 0 with data 0xDEADBEEF, then addr 1 with data 0x01234567;
  - `boot_done` pulses 1 cycle after the second strobe, as `boot_mode` falls.
- Same image with random 0–20-cycle gaps between bytes: identical writes, no extra strobes.
- N=0 → `boot_error`=1 and `boot_mode`=0 one cycle after the 4th byte; no writes.
- TIMEOUT_CYCLES=16, stop after 2 data bytes → ERROR 17 cycles after the last byte; no write for the partial word. A following `boot_start` clears `boot_error` and reloads cleanly.
- Assert `rst_n` low mid-word → all outputs zero immediately, state IDLE; bytes received after reset are ignored until `boot_start`.
- `boot_start` pulsed during DATA and `rx_valid` bytes in IDLE → both ignored; addresses remain contiguous.

Source files
------------

// File: rtl/boot_loader_ctrl_pkg.sv
// Shared definitions for the boot loader: state encoding, word geometry and
// the image length legality check.
package boot_loader_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA,
        ST_DONE,
        ST_ERROR
    } boot_state_t;

    localparam int BYTES_PER_WORD = 4;

    // A word count of exactly 2^addr_w is legal; zero or anything larger is not.
    function automatic logic len_ok(input logic [31:0] n, input int addr_w);
        logic [32:0] limit;
        limit  = 33'd1 << addr_w;
        len_ok = (n != 32'd0) && ({1'b0, n} <= limit);
    endfunction

endpackage

// File: rtl/boot_loader_ctrl_byte_packer.sv
// Big-endian byte-to-word assembler. word/word_valid are combinational so the
// caller can register the completed word on the same edge as its 4th byte.
module byte_packer
    import boot_loader_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [23:0] shift_q;
    logic [1:0]  idx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= 2'd0;
        end else if (clear) begin
            idx_q <= 2'd0;
        end else if (rx_valid) begin
            idx_q <= idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rx_valid) begin
            shift_q <= {shift_q[15:0], rx_data};
        end
    end

    assign word       = {shift_q, rx_data};
    assign word_valid = rx_valid && !clear && (idx_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/boot_loader_ctrl.sv
// Boot loader: receives a length-prefixed image over the UART byte stream and
// writes it into instruction SRAM, then hands the SRAM back to the DLX.
module boot_loader_ctrl
    import boot_loader_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 20,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  boot_start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  boot_mode,
    output logic                  boot_mem_wr_en,
    output logic [ADDR_WIDTH-1:0] boot_mem_addr,
    output logic [DATA_WIDTH-1:0] boot_mem_rd_data,
    output logic                  boot_done,
    output logic                  boot_error
);

    localparam int CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int WCNT_W = ADDR_WIDTH + 1;

    boot_state_t       state_q, state_d;
    logic [CNT_W-1:0]  tmo_q;
    logic [WCNT_W-1:0] word_idx_q;
    logic [WCNT_W-1:0] n_words_q;
    logic              last_q;

    logic        start_ok;
    logic        in_xfer;
    logic        expired;
    logic        accept;
    logic [31:0] word;
    logic        word_valid;
    logic        len_good;

    logic mode_d, done_d, error_d, wr_en_d;

    assign start_ok = boot_start && (state_q inside {ST_IDLE, ST_DONE, ST_ERROR});
    assign in_xfer  = (state_q == ST_LEN) || (state_q == ST_DATA);
    assign expired  = tmo_q >= CNT_W'(TIMEOUT_CYCLES);
    // last_q blocks bytes during the final write cycle, before DONE is entered.
    assign accept   = rx_valid && in_xfer && !expired && !last_q;
    assign len_good = len_ok(word, ADDR_WIDTH);

    byte_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (start_ok),
        .rx_valid   (accept),
        .rx_data    (rx_data),
        .word       (word),
        .word_valid (word_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start_ok) state_d = ST_LEN;
            end
            ST_LEN: begin
                if (expired)         state_d = ST_ERROR;
                else if (word_valid) state_d = len_good ? ST_DATA : ST_ERROR;
            end
            ST_DATA: begin
                if (last_q)       state_d = ST_DONE;
                else if (expired) state_d = ST_ERROR;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are derived from the next state so every port is a flop.
    always_comb begin
        mode_d  = (state_d == ST_LEN) || (state_d == ST_DATA);
        done_d  = (state_d == ST_DONE) && (state_q != ST_DONE);
        error_d = (state_d == ST_ERROR);
        wr_en_d = word_valid && (state_q == ST_DATA);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            boot_mode        <= 1'b0;
            boot_done        <= 1'b0;
            boot_error       <= 1'b0;
            boot_mem_wr_en   <= 1'b0;
            boot_mem_addr    <= '0;
            boot_mem_rd_data <= '0;
        end else begin
            boot_mode      <= mode_d;
            boot_done      <= done_d;
            boot_error     <= error_d;
            boot_mem_wr_en <= wr_en_d;
            if (start_ok) begin
                boot_mem_addr <= '0;
            end else if (wr_en_d) begin
                boot_mem_addr    <= word_idx_q[ADDR_WIDTH-1:0];
                boot_mem_rd_data <= DATA_WIDTH'(word);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q      <= '0;
            word_idx_q <= '0;
            n_words_q  <= '0;
            last_q     <= 1'b0;
        end else if (start_ok) begin
            tmo_q      <= CNT_W'(1);
            word_idx_q <= '0;
            last_q     <= 1'b0;
        end else if (in_xfer) begin
            if (accept)        tmo_q <= CNT_W'(1);
            else if (!expired) tmo_q <= tmo_q + CNT_W'(1);
            if ((state_q == ST_LEN) && word_valid && len_good) begin
                n_words_q <= word[WCNT_W-1:0];
            end
            // The word counter is one bit wider than the address, so a full
            // 2^ADDR_WIDTH image terminates before it could wrap.
            if (wr_en_d) begin
                word_idx_q <= word_idx_q + WCNT_W'(1);
                if ((word_idx_q + WCNT_W'(1)) == n_words_q) last_q <= 1'b1;
            end
        end
    end

endmodule
